// File: rtl/seg_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment display path.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  // True when exactly one bit is set.
  function automatic logic onehot_valid(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/seg_display_mux_bcd_to_seg.sv
// BCD digit to active-low 7-segment pattern; non-decimal codes render as a dash.
module bcd_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = SEG_DASH;
    case (bcd)
      4'd0: pattern = SEG_0;
      4'd1: pattern = SEG_1;
      4'd2: pattern = SEG_2;
      4'd3: pattern = SEG_3;
      4'd4: pattern = SEG_4;
      4'd5: pattern = SEG_5;
      4'd6: pattern = SEG_6;
      4'd7: pattern = SEG_7;
      4'd8: pattern = SEG_8;
      4'd9: pattern = SEG_9;
      default: pattern = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_display_mux.sv
// 4-digit multiplexed 7-segment driver: shadow digit buffer, blink timer,
// leading-zero suppression and registered anode/segment/dp outputs.
module seg_display_mux
  import seg_pkg::*;
#(
  parameter int BLINK_DIV = 25_000_000,
  parameter int CNT_W     = 25
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  selector,
  input  logic        load,
  input  logic [15:0] digits,
  input  logic [3:0]  blink_mask,
  input  logic        lz_suppress,
  input  logic        colon_in,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        blink_phase
);

  logic [15:0]      digit_buf;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic             sel_ok;
  logic [3:0]       cur_digit;
  logic [6:0]       pattern;
  logic             blank;

  // Display reads only the shadow copy so a scan never mixes old/new digits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     digit_buf <= 16'h0000;
    else if (load) digit_buf <= digits;
  end

  // Load restarts the visible half so an edited digit shows at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      blink_phase <= 1'b0;
    end else if (load) begin
      cnt         <= '0;
      blink_phase <= 1'b0;
    end else if (cnt == CNT_W'(BLINK_DIV - 1)) begin
      cnt         <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      cnt         <= cnt + CNT_W'(1);
    end
  end

  always_comb begin
    idx = 2'd0;
    case (selector)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
  end

  assign sel_ok    = onehot_valid(selector);
  assign cur_digit = digit_buf[{idx, 2'b00} +: 4];
  assign blank     = (blink_mask[idx] & blink_phase) |
                     ((idx == 2'd3) & lz_suppress & (digit_buf[15:12] == 4'd0));

  bcd_to_seg u_bcd_to_seg (
    .bcd     (cur_digit),
    .pattern (pattern)
  );

  // Anode stays on while a digit is blanked so the scan duty is unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an  <= AN_OFF;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else if (!sel_ok) begin
      an  <= AN_OFF;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= ~selector;
      seg <= blank ? SEG_BLANK : pattern;
      dp  <= ~((idx == 2'd2) & colon_in);
    end
  end

endmodule

// File: tb/tb_seg_display_mux.sv
// Directed self-checking bench for seg_display_mux with a 4-cycle blink half-period.
module tb_seg_display_mux;

  logic        clk;
  logic        reset;
  logic [3:0]  selector;
  logic        load;
  logic [15:0] digits;
  logic [3:0]  blink_mask;
  logic        lz_suppress;
  logic        colon_in;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        blink_phase;

  int n_tests = 0;
  int n_fail  = 0;

  seg_display_mux #(.BLINK_DIV(4), .CNT_W(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .selector    (selector),
    .load        (load),
    .digits      (digits),
    .blink_mask  (blink_mask),
    .lz_suppress (lz_suppress),
    .colon_in    (colon_in),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .blink_phase (blink_phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_blank(input string tag);
    chk({tag, "_an"},  32'(an),  32'b1111);
    chk({tag, "_seg"}, 32'(seg), 32'b1111111);
    chk({tag, "_dp"},  32'(dp),  32'b1);
  endtask

  // Digit patterns for the 1234 sweep, indexed by selector position.
  logic [6:0] sweep_seg [4];
  logic [3:0] sweep_an  [4];

  initial begin
    sweep_seg[0] = 7'b0011001; sweep_an[0] = 4'b1110;
    sweep_seg[1] = 7'b0110000; sweep_an[1] = 4'b1101;
    sweep_seg[2] = 7'b0100100; sweep_an[2] = 4'b1011;
    sweep_seg[3] = 7'b1111001; sweep_an[3] = 4'b0111;

    reset = 1'b1; selector = 4'b0000; load = 1'b0; digits = 16'h0000;
    blink_mask = 4'b0000; lz_suppress = 1'b0; colon_in = 1'b0;
    #2;
    reset = 1'b0; load = 1'b1; digits = 16'h1234; selector = 4'b0001;
    tick();                       // t=6, buf <= 1234
    load = 1'b0;
    tick();                       // t=16
    chk("pre_an",  32'(an),  32'b1110);
    chk("pre_seg", 32'(seg), 32'b0011001);

    // 1. asynchronous mid-cycle reset at t=20
    #4;
    reset = 1'b1;
    #1;
    chk_blank("rst");
    chk("rst_phase", 32'(blink_phase), 32'b0);
    #1;
    reset = 1'b0;
    tick();                       // buffer was cleared: digit 0 shows "0"
    chk("post_rst_an",  32'(an),  32'b1110);
    chk("post_rst_seg", 32'(seg), 32'b1000000);

    load = 1'b1; digits = 16'h1234;
    tick();
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      selector = 4'b0001 << i;
      tick();
      chk("sweep_an",  32'(an),  32'(sweep_an[i]));
      chk("sweep_seg", 32'(seg), 32'(sweep_seg[i]));
      chk("sweep_dp",  32'(dp),  32'b1);
    end

    // 2. blink on digit 0
    selector = 4'b0001; blink_mask = 4'b0001; load = 1'b1;
    tick();
    load = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("blink_phase", 32'(blink_phase), 32'((k / 4) % 2));
      chk("blink_seg", 32'(seg), ((((k - 1) / 4) % 2) != 0) ? 32'b1111111 : 32'b0011001);
      chk("blink_an", 32'(an), 32'b1110);
    end

    // load mid-blank restarts the visible half
    load = 1'b1;
    tick();
    load = 1'b0;
    for (int k = 1; k <= 5; k++) tick();
    chk("reload_pre", 32'(blink_phase), 32'b1);
    load = 1'b1;
    tick();
    load = 1'b0;
    chk("reload_phase", 32'(blink_phase), 32'b0);
    for (int k = 1; k <= 3; k++) tick();
    chk("reload_hold", 32'(blink_phase), 32'b0);
    tick();
    chk("reload_wrap", 32'(blink_phase), 32'b1);

    // 6. load on the wrap edge beats the toggle
    load = 1'b1;
    tick();
    load = 1'b0;
    for (int k = 1; k <= 3; k++) tick();
    load = 1'b1;
    tick();
    load = 1'b0;
    chk("coll_phase", 32'(blink_phase), 32'b0);
    for (int k = 1; k <= 3; k++) tick();
    chk("coll_hold", 32'(blink_phase), 32'b0);
    tick();
    chk("coll_wrap", 32'(blink_phase), 32'b1);

    // 3. leading-zero suppression
    blink_mask = 4'b0000; digits = 16'h0930; lz_suppress = 1'b1;
    selector = 4'b1000; load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    chk("lz_seg", 32'(seg), 32'b1111111);
    chk("lz_an",  32'(an),  32'b0111);
    selector = 4'b0100;
    tick();
    chk("lz_d2_seg", 32'(seg), 32'b0010000);
    selector = 4'b1000; lz_suppress = 1'b0;
    tick();
    chk("nolz_seg", 32'(seg), 32'b1000000);

    // 4. colon survives blink blanking
    colon_in = 1'b1; blink_mask = 4'b0100; selector = 4'b0100; load = 1'b1;
    tick();
    load = 1'b0;
    for (int k = 1; k <= 4; k++) tick();
    chk("colon_phase", 32'(blink_phase), 32'b1);
    tick();
    chk("colon_seg", 32'(seg), 32'b1111111);
    chk("colon_dp",  32'(dp),  32'b0);
    chk("colon_an",  32'(an),  32'b1011);
    selector = 4'b0010;
    tick();
    chk("colon_d1_dp",  32'(dp),  32'b1);
    chk("colon_d1_seg", 32'(seg), 32'b0110000);

    // 5. invalid selectors and non-decimal digits
    selector = 4'b0000;
    tick();
    chk_blank("sel0000");
    selector = 4'b0011;
    tick();
    chk_blank("sel0011");
    selector = 4'b1100;
    tick();
    chk_blank("sel1100");
    blink_mask = 4'b0000; colon_in = 1'b0; digits = 16'hF00B;
    selector = 4'b0001; load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    chk("bcd_b_seg", 32'(seg), 32'b0111111);
    selector = 4'b1000; lz_suppress = 1'b1;
    tick();
    chk("bcd_f_seg", 32'(seg), 32'b0111111);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
